// File: rtl/eb_fifo_if.sv
// eb_fifo_if: valid/ready stream bundle carrying one data word per beat.
// The master drives data/valid and the slave drives ready.
interface eb_fifo_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/eb_fifo.sv
// eb_fifo: parametrised elastic buffer (DEPTH entries) between a valid/ready
// producer (t_0) and consumer (i_0). Full throughput, occupancy on 'level'.
// Optional empty-bypass is enabled by defining EB_FIFO_BYPASS_EN: while the
// buffer is empty, t_0 is presented combinationally on i_0, and a word that
// the consumer takes in that same cycle is never written to storage.
module eb_fifo #(
  parameter int T_0_WIDTH = 8,
  parameter int I_0_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  eb_fifo_if.slave                   t_0,
  eb_fifo_if.master                  i_0,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  // Storage only needs the narrower of the two widths: extra input bits are
  // dropped on truncation and extra output bits are zeros on extension.
  localparam int SW = (T_0_WIDTH < I_0_WIDTH) ? T_0_WIDTH : I_0_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [SW-1:0]        r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_out_valid;
  logic [SW-1:0]        w_wdata;
  logic [I_0_WIDTH-1:0] w_head_ext;

  assign w_wdata = t_0.data[SW-1:0];
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Ready depends only on the count register, so there is no
  // combinational path from i_0.ready back to t_0.ready.
  assign t_0.ready = ~w_full;
  assign w_push    = t_0.valid & ~w_full;
  assign w_pop     = w_out_valid & i_0.ready;

  // Zero-extend the head entry to the output width.
  always_comb begin
    w_head_ext           = '0;
    w_head_ext[SW-1:0]   = r_mem[r_rd_ptr];
  end

`ifdef EB_FIFO_BYPASS_EN
  logic [I_0_WIDTH-1:0] w_in_ext;

  // Zero-extend the incoming word for the empty-bypass path.
  always_comb begin
    w_in_ext             = '0;
    w_in_ext[SW-1:0]     = w_wdata;
  end

  assign w_out_valid = w_empty ? t_0.valid : 1'b1;
  assign i_0.data    = w_empty ? w_in_ext : w_head_ext;
  // A word consumed in the same cycle it arrives at an empty buffer skips storage.
  assign w_wr        = w_push & ~(w_empty & i_0.ready);
  assign w_rd        = w_pop & ~w_empty;
`else
  assign w_out_valid = ~w_empty;
  assign i_0.data    = w_head_ext;
  assign w_wr        = w_push;
  assign w_rd        = w_pop;
`endif

  assign i_0.valid = w_out_valid;
  assign level     = r_count;

  // Write pointer advances on every stored word, wrapping at DEPTH-1 by compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
    end else if (w_wr) begin
      r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on every pop from storage, same wrap rule.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
    end else if (w_rd) begin
      r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: +1 on write only, -1 on read only, unchanged otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage entries clear on reset so the output word reads zero afterwards.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Each entry captures the incoming word when the write pointer selects it.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_mem[gi] <= '0;
        end else if (w_wr && (r_wr_ptr == PW'(gi))) begin
          r_mem[gi] <= w_wdata;
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_eb_fifo.sv
// tb_eb_fifo: self-checking bench for eb_fifo. Two instances (DEPTH=4 and
// DEPTH=3) are driven one at a time; a queue scoreboard predicts every output.
// Bypass expectations follow EB_FIFO_BYPASS_EN when it is defined.
module tb_eb_fifo;
`ifdef EB_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] level4;
  logic [1:0] level3;

  always #5 clk = ~clk;

  eb_fifo_if #(.W(8)) t4 ();
  eb_fifo_if #(.W(8)) i4 ();
  eb_fifo_if #(.W(8)) t3 ();
  eb_fifo_if #(.W(8)) i3 ();

  eb_fifo #(.T_0_WIDTH(8), .I_0_WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .t_0(t4), .i_0(i4), .level(level4)
  );
  eb_fifo #(.T_0_WIDTH(8), .I_0_WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .t_0(t3), .i_0(i3), .level(level3)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] q4[$];
  logic [7:0] q3[$];

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         rdy;
    bit         e_ready;
    bit         e_valid;
    logic [7:0] e_data;
    int         e_level;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // One clock cycle on the selected instance (0: DEPTH=4, 1: DEPTH=3):
  // drive at negedge, compare against the scoreboard, update the model.
  task automatic cycle(input int sel, input bit v, input logic [7:0] d, input bit rdy,
                       output bit a_rdy, output bit a_val, output logic [7:0] a_data,
                       output int a_lvl);
    int         depth;
    int         cnt;
    bit         e_rdy, e_val, push, pop;
    logic [7:0] e_data;
    @(negedge clk);
    t4.valid = (sel == 0) ? v : 1'b0;
    t4.data  = (sel == 0) ? d : 8'h00;
    i4.ready = (sel == 0) ? rdy : 1'b0;
    t3.valid = (sel == 1) ? v : 1'b0;
    t3.data  = (sel == 1) ? d : 8'h00;
    i3.ready = (sel == 1) ? rdy : 1'b0;
    #1;
    depth  = (sel == 1) ? 3 : 4;
    cnt    = (sel == 1) ? q3.size() : q4.size();
    e_rdy  = (cnt != depth);
    e_val  = (cnt != 0) || (BYP && v);
    push   = v && e_rdy;
    pop    = e_val && rdy;
    e_data = (cnt == 0) ? d : ((sel == 1) ? q3[0] : q4[0]);
    a_rdy  = (sel == 1) ? t3.ready : t4.ready;
    a_val  = (sel == 1) ? i3.valid : i4.valid;
    a_data = (sel == 1) ? i3.data : i4.data;
    a_lvl  = (sel == 1) ? int'(level3) : int'(level4);
    chk("t_0_ready", 32'(a_rdy), 32'(e_rdy));
    chk("i_0_valid", 32'(a_val), 32'(e_val));
    chk("level", 32'(a_lvl), 32'(cnt));
    if (e_val) chk("i_0_data", 32'(a_data), 32'(e_data));
    $display("dut%0d v=%0b d=%02h rdy=%0b -> t_rdy=%0b o_val=%0b o_data=%02h level=%0d",
             depth, v, d, rdy, a_rdy, a_val, a_data, a_lvl);
    if (!(BYP && cnt == 0 && push && rdy)) begin
      if (sel == 1) begin
        if (push) q3.push_back(d);
        if (pop)  void'(q3.pop_front());
      end else begin
        if (push) q4.push_back(d);
        if (pop)  void'(q4.pop_front());
      end
    end
  endtask

  task automatic step(input int sel, input bit v, input logic [7:0] d, input bit rdy);
    bit         r, vl;
    logic [7:0] dt;
    int         l;
    cycle(sel, v, d, rdy, r, vl, dt, l);
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_level4"}, 32'(level4), 32'd0);
    chk({tag, "_valid4"}, 32'(i4.valid), 32'd0);
    chk({tag, "_ready4"}, 32'(t4.ready), 32'd1);
    chk({tag, "_data4"},  32'(i4.data), 32'd0);
    chk({tag, "_level3"}, 32'(level3), 32'd0);
    chk({tag, "_valid3"}, 32'(i3.valid), 32'd0);
  endtask

  initial begin
    vec_t       vecs[10];
    bit         r, vl;
    logic [7:0] dt;
    int         l;

    // Fill to full, reject a 5th word, then drain (values observed before each edge).
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, BYP,  (BYP ? 8'h11 : 8'h00), 0};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 2};
    vecs[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h11, 3};
    vecs[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 4};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 4};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 1};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0};

    t4.valid = 1'b0; t4.data = 8'h00; i4.ready = 1'b0;
    t3.valid = 1'b0; t3.data = 8'h00; i3.ready = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    idle_check("in_reset");
    reset_n = 1'b1;
    #1;
    idle_check("after_reset");

    for (int k = 0; k < 10; k++) begin
      cycle(0, vecs[k].v, vecs[k].d, vecs[k].rdy, r, vl, dt, l);
      chk($sformatf("vec%0d_ready", k), 32'(r), 32'(vecs[k].e_ready));
      chk($sformatf("vec%0d_valid", k), 32'(vl), 32'(vecs[k].e_valid));
      chk($sformatf("vec%0d_level", k), 32'(l), 32'(vecs[k].e_level));
      if (vecs[k].e_valid) chk($sformatf("vec%0d_data", k), 32'(dt), 32'(vecs[k].e_data));
    end

    // Streaming through DEPTH=3: 10 words back-to-back, pointers wrap.
    for (int k = 0; k < 10; k++) begin
      cycle(1, 1'b1, 8'(k), 1'b1, r, vl, dt, l);
      chk($sformatf("stream%0d_level", k), 32'(l), (k == 0 || BYP) ? 32'd0 : 32'd1);
    end
    step(1, 1'b0, 8'h00, 1'b1);
    chk("stream_drained", 32'(q3.size()), 32'd0);

    // Backpressure stall: head 0xA5 must hold for 5 cycles, then pop.
    step(0, 1'b1, 8'hA5, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(0, (k == 2), 8'h5A, 1'b0, r, vl, dt, l);
      chk($sformatf("stall%0d_data", k), 32'(dt), 32'hA5);
    end
    step(0, 1'b0, 8'h00, 1'b1);
    step(0, 1'b0, 8'h00, 1'b1);
    chk("stall_drained", 32'(q4.size()), 32'd0);

`ifdef EB_FIFO_BYPASS_EN
    // Empty bypass: same-cycle delivery, no storage when consumed.
    cycle(0, 1'b1, 8'h3C, 1'b1, r, vl, dt, l);
    chk("byp_valid", 32'(vl), 32'd1);
    chk("byp_data", 32'(dt), 32'h3C);
    #1 chk("byp_level", 32'(level4), 32'd0);
    step(0, 1'b1, 8'h3C, 1'b0);
    #1 chk("byp_stored_level", 32'(level4), 32'd1);
    step(0, 1'b0, 8'h00, 1'b1);
`endif

    // Random traffic on the non-power-of-2 instance, then drain.
    for (int k = 0; k < 150; k++) begin
      step(1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 4; k++) step(1, 1'b0, 8'h00, 1'b1);
    chk("random_drained", 32'(q3.size()), 32'd0);

    // Asynchronous reset mid-operation discards contents immediately.
    step(0, 1'b1, 8'hC1, 1'b0);
    step(0, 1'b1, 8'hC2, 1'b0);
    @(negedge clk);
    t4.valid = 1'b0; i4.ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    idle_check("mid_reset");
    q4.delete();
    q3.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 1'b1, 8'h77, 1'b0);
    cycle(0, 1'b0, 8'h00, 1'b1, r, vl, dt, l);
    chk("post_reset_data", 32'(dt), 32'h77);
    chk("post_reset_level", 32'(l), 32'd1);
    step(0, 1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eb_fifo.md
Name: eb_fifo

Overview:
- Parametrised elastic buffer with DEPTH entries, the successor to the fixed 1.5-entry elastic buffer.
- Sits between a valid/ready producer (t_0) and consumer (i_0) in the same stream fabric.
- Sustains full throughput and adds configurable depth, an occupancy output, and optional empty-bypass.

Parameters:
- T_0_WIDTH, 8, target (input) data width in bits.
- I_0_WIDTH, 8, initiator (output) data width in bits.
- DEPTH, 4, number of storage entries; legal range 2..256; non-power-of-2 values allowed.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- t_0_data  input  T_0_WIDTH  incoming data.
- t_0_valid  input  1  incoming data valid.
- t_0_ready  output  1  buffer can accept a word this cycle.
- i_0_data  output  I_0_WIDTH  outgoing data.
- i_0_valid  output  1  outgoing data valid.
- i_0_ready  input  1  consumer accepts a word this cycle.
- level  output  $clog2(DEPTH+1)  current number of stored entries.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values: count=0, wr_ptr=0, rd_ptr=0, all storage entries=0, level=0, i_0_valid=0, t_0_ready=1, i_0_data=0.
- push = t_0_valid & t_0_ready; pop = i_0_valid & i_0_ready.
- t_0_ready = (count != DEPTH). Derived from the count register only; no combinational path from i_0_ready.
- i_0_valid = (count != 0). i_0_data = mem[rd_ptr], width-adjusted.
- Latency: a word pushed into an empty buffer appears on i_0 in the next cycle (1-cycle latency).
- Throughput: one push and one pop per cycle whenever 0 < count < DEPTH.
- Count update: push only, +1; pop only, -1; both or neither, unchanged.
- Pointer wrap: each pointer advances on its event and wraps from DEPTH-1 to 0; this is explicit compare, not power-of-2 masking.
- Full: t_0_ready=0 and t_0_data is ignored. A pop while full leaves count=DEPTH-1; ready rises the next cycle.
- Empty: i_0_valid=0 and i_0_ready is ignored. No underflow, no pointer motion.
- Ordering: strictly FIFO; no word is dropped or duplicated.
- Stability: while i_0_valid=1 and i_0_ready=0, i_0_valid and i_0_data hold.
- Width rule:
  - I_0_WIDTH > T_0_WIDTH: zero-extend in the MSBs.
  - I_0_WIDTH < T_0_WIDTH: truncate to the LSBs.
  - Storage is min(T_0_WIDTH, I_0_WIDTH) bits.
- level = count, registered.
- Reset mid-operation: all contents are discarded immediately (async). Outputs take reset values while reset_n=0. The first push after release behaves as if the buffer were empty.

Optional Feature:
- Macro: EB_FIFO_BYPASS_EN.
- Defined, when count==0:
  - i_0_valid = t_0_valid and i_0_data = t_0_data (width-adjusted); combinational path, 0-cycle latency.
  - If i_0_ready=1 in that cycle, the word bypasses storage: no write, count stays 0.
  - If i_0_ready=0, the word is written; count becomes 1.
  - Behaviour at count>0 is unchanged.
- Undefined: no combinational t_0 to i_0 path; 1-cycle minimum latency as above.

Test Plan:
- Reset then idle: reset_n=0 for 3 cycles, release -> level=0, i_0_valid=0, t_0_ready=1, i_0_data=0.
- Fill, DEPTH=4: push 0x11,0x22,0x33,0x44 with i_0_ready=0 -> level=4 and t_0_ready=0 after the 4th push; a 5th word 0x55 is not accepted.
- Drain: from full, i_0_ready=1 for 4 cycles -> outputs 0x11,0x22,0x33,0x44 in order; level falls 3,2,1,0; t_0_ready=1 one cycle after the first pop.
- Streaming, DEPTH=3 (non-power-of-2): t_0_valid=1 and i_0_ready=1 continuously, 10 words 0x00..0x09 -> all delivered in order with 1-cycle latency; pointers wrap; level stays 1.
- Backpressure stall: i_0_valid=1 with 0xA5 at the head, i_0_ready=0 for 5 cycles -> i_0_data stays 0xA5 throughout; pop on release.
- Bypass, EB_FIFO_BYPASS_EN defined: empty, t_0_valid=1 with 0x3C, i_0_ready=1 -> i_0_valid=1 with 0x3C in the same cycle, level stays 0. Repeat with i_0_ready=0 -> level=1 next cycle.
